mult_controller: RTL and testbench

Sequencing FSM for the radix-2 Booth multiplier datapath. It accepts a start request and drives the datapath's `mult_control_t` bundle: load operands, then N iterations of conditional add/subtract followed by an arithmetic shift. It reads the datapath's `Q_LSB` pair to choose each operation and signals completion with a one-cycle `done` pulse. It sits beside the datapath inside the multiplier top and is the only driver of `mult_control`.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/mult_iter_cnt.sv | 26 ++
 rtl/mult_controller.sv | 90 +++++++++
 tb/tb_mult_controller.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and Q_LSB codes for the Booth multiplier controller and datapath
package mult_pkg;

  typedef struct packed {
    logic load_A;
    logic load_B;
    logic load_add;
    logic add_sub;
    logic shift_HQ_LQ_Q_1;
  } mult_control_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD,
    ST_SHIFT,
    ST_DONE
  } mult_state_t;

  // {Q0, Q_1} Booth recoding pairs
  localparam logic [1:0] QLSB_NOP0 = 2'b00;
  localparam logic [1:0] QLSB_ADD  = 2'b01;
  localparam logic [1:0] QLSB_SUB  = 2'b10;
  localparam logic [1:0] QLSB_NOP1 = 2'b11;

endpackage

// File: rtl/mult_iter_cnt.sv
// rtl/mult_iter_cnt.sv - Booth iteration counter with clear, increment and last-iteration flag
module mult_iter_cnt #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign last = (count == W'(N - 1));

endmodule

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - Booth multiplier sequencing FSM; MULT_CTRL_SKIP_EN folds no-op iterations into one cycle
module mult_controller
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    Q_LSB,
  output logic          ready,
  output logic          done,
  output mult_control_t mult_control
);

  mult_state_t state;
  mult_state_t next_state;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        last;
  logic        is_add;
  logic        is_sub;

  mult_iter_cnt #(.N(N)) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign is_add = (Q_LSB == QLSB_ADD);
  assign is_sub = (Q_LSB == QLSB_SUB);

  always_comb begin
    next_state   = state;
    mult_control = '0;
    ready        = 1'b0;
    done         = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        mult_control.load_A = 1'b1;
        mult_control.load_B = 1'b1;
        cnt_clr             = 1'b1;
        next_state          = ST_ADD;
      end
      ST_ADD: begin
        mult_control.load_add = is_add || is_sub;
        mult_control.add_sub  = is_add;
`ifdef MULT_CTRL_SKIP_EN
        // A no-op pair shifts immediately instead of spending a cycle in SHIFT
        if (is_add || is_sub) begin
          next_state = ST_SHIFT;
        end else begin
          mult_control.shift_HQ_LQ_Q_1 = 1'b1;
          cnt_inc                      = 1'b1;
          next_state                   = last ? ST_DONE : ST_ADD;
        end
`else
        next_state = ST_SHIFT;
`endif
      end
      ST_SHIFT: begin
        mult_control.shift_HQ_LQ_Q_1 = 1'b1;
        cnt_inc                      = 1'b1;
        next_state                   = last ? ST_DONE : ST_ADD;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// tb/tb_mult_controller.sv - scoreboard bench for mult_controller with a behavioural Booth datapath
module tb_mult_controller;
  import mult_pkg::*;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    Q_LSB;
  logic          ready;
  logic          done;
  mult_control_t mc;

  always #5 clk = ~clk;

  mult_controller #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Q_LSB        (Q_LSB),
    .ready        (ready),
    .done         (done),
    .mult_control (mc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Behavioural Booth datapath; H carries one guard bit so -2^(N-1) operands are exact
  logic [N-1:0]        op_a, op_b;
  logic signed [N:0]   dp_h;
  logic signed [N-1:0] dp_m;
  logic [N-1:0]        dp_q;
  logic                dp_q1;
  logic                force_en;
  logic [1:0]          force_q;

  assign Q_LSB = force_en ? force_q : {dp_q[0], dp_q1};

  always @(posedge clk) begin : datapath
    logic signed [N:0] h;
    h = dp_h;
    if (mc.load_A) dp_m <= op_a;
    if (mc.load_B) begin
      dp_q  <= op_b;
      dp_q1 <= 1'b0;
      h = '0;
    end
    if (mc.load_add) h = mc.add_sub ? h + dp_m : h - dp_m;
    if (mc.shift_HQ_LQ_Q_1) {dp_h, dp_q, dp_q1} <= {h[N], h, dp_q};
    else dp_h <= h;
  end

  typedef struct {
    logic           chk_y;
    logic [2*N-1:0] y;
    int             lat;
    int             adds;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t make_exp(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    logic signed [2*N-1:0] ea, eb;
    logic prev;
    int k;
    ea = {{N{a[N-1]}}, a};
    eb = {{N{b[N-1]}}, b};
    k = 0;
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (b[i] != prev) k++;
      prev = b[i];
    end
    e.chk_y = 1'b1;
    e.y     = ea * eb;
    e.adds  = k;
`ifdef MULT_CTRL_SKIP_EN
    e.lat = N + 2 + k;
`else
    e.lat = 2 * N + 2;
`endif
    return e;
  endfunction

  // Monitor: per-cycle invariants, latency/add-count measurement, scoreboard pop
  int   gcyc = 0;
  int   op_cyc = 0;
  int   add_cnt = 0;
  int   done_cnt = 0;
  int   last_done_g = -100;
  int   last_gap = 0;
  logic active = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    gcyc++;
    if (rst) begin
      active = 1'b0;
    end else begin
      check("excl_add_shift", mc.load_add & mc.shift_HQ_LQ_Q_1, 0);
      check("addsub_gated", mc.add_sub & ~mc.load_add, 0);
      if (active) begin
        op_cyc++;
        if (mc.load_add) add_cnt++;
      end
      if (done) begin
        check("done_width", prev_done, 0);
        if (exp_q.size() == 0) begin
          check("sb_underflow", done, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", op_cyc, e.lat);
          check("add_pulses", add_cnt, e.adds);
          if (e.chk_y) check("product", {dp_h[N-1:0], dp_q}, e.y);
        end
        done_cnt++;
        last_done_g = gcyc;
        active = 1'b0;
      end
      if (ready && start) begin
        last_gap = gcyc - last_done_g;
        active   = 1'b1;
        op_cyc   = 0;
        add_cnt  = 0;
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 50) begin
      tick();
      t++;
    end
    check("ready_timeout", ready, 1);
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 60) begin
      tick();
      t++;
    end
    check("done_timeout", done_cnt, target);
    tick();
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    int base;
    wait_ready();
    op_a = a;
    op_b = b;
    exp_q.push_back(make_exp(a, b));
    base  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(base + 1);
  endtask

  task automatic chk_ctrl(input string tag, input logic la, input logic as, input logic sh);
    #1;
    check({tag, "_load_add"}, mc.load_add, la);
    check({tag, "_add_sub"}, mc.add_sub, as);
    check({tag, "_shift"}, mc.shift_HQ_LQ_Q_1, sh);
  endtask

  initial begin
    int   base;
    int   seen;
    int   t;
    exp_t e;

    rst = 1'b1; start = 1'b0; force_en = 1'b0; force_q = 2'b00;
    op_a = '0; op_b = '0;
    tick();
    tick();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_ctrl", mc, 0);
    rst = 1'b0;
    tick();

    // Directed and random products
    run_op(8'd7, 8'd0);
    run_op(8'd5, 8'hFF);
    run_op(8'h80, 8'h80);
    run_op(8'h7F, 8'h81);
    run_op(8'd3, 8'h55);
    for (int i = 0; i < 6; i++) run_op(N'($urandom), N'($urandom));

    // Forced Q_LSB sequence 01, 10, 00, 11
    wait_ready();
    force_en = 1'b1;
    force_q  = 2'b01;
    e.chk_y = 1'b0;
    e.y     = '0;
    e.adds  = 2;
`ifdef MULT_CTRL_SKIP_EN
    e.lat = N + 4;
`else
    e.lat = 2 * N + 2;
`endif
    exp_q.push_back(e);
    base  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_ctrl("f01", 1, 1, 0);
    tick();
    chk_ctrl("f01_sh", 0, 0, 1);
    force_q = 2'b10;
    tick();
    chk_ctrl("f10", 1, 0, 0);
    tick();
    chk_ctrl("f10_sh", 0, 0, 1);
    force_q = 2'b00;
    tick();
`ifdef MULT_CTRL_SKIP_EN
    chk_ctrl("f00", 0, 0, 1);
    force_q = 2'b11;
    tick();
    chk_ctrl("f11", 0, 0, 1);
`else
    chk_ctrl("f00", 0, 0, 0);
    tick();
    chk_ctrl("f00_sh", 0, 0, 1);
    force_q = 2'b11;
    tick();
    chk_ctrl("f11", 0, 0, 0);
    tick();
    chk_ctrl("f11_sh", 0, 0, 1);
`endif
    force_q = 2'b00;
    wait_done(base + 1);
    force_en = 1'b0;

    // Reset asserted in cycle 7 of an operation
    wait_ready();
    op_a = 8'd3;
    op_b = 8'd5;
    exp_q.push_back(make_exp(op_a, op_b));
    base  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_ctrl", mc, 0);
    repeat (20) tick();
    check("midrst_no_done", done_cnt, base);
    run_op(8'd3, 8'd5);

    // Start pulses in cycle 3 and in the DONE cycle are ignored
    wait_ready();
    op_a = 8'hFD;
    op_b = 8'h5A;
    e = make_exp(op_a, op_b);
    exp_q.push_back(e);
    base  = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (e.lat - 4) tick();
    check("busy_done_cycle", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("ignored_starts", done_cnt, base + 1);
    check("ignored_idle", ready, 1);

    // Start held high: second operation accepted one cycle after done
    wait_ready();
    op_a = 8'h9C;
    op_b = 8'h3B;
    exp_q.push_back(make_exp(op_a, op_b));
    exp_q.push_back(make_exp(op_a, op_b));
    seen  = 0;
    t     = 0;
    start = 1'b1;
    while (t < 100) begin
      tick();
      t++;
      if (done) begin
        seen++;
        if (seen == 2) break;
      end
    end
    start = 1'b0;
    check("held_ops", seen, 2);
    check("held_gap", last_gap, 1);
    repeat (3) tick();
    check("held_no_third", ready, 1);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
